// File: rtl/pam_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module : pam_mul_arbiter
// Round-robin arbiter sharing one exact/approximate 8x8 multiplier core.
// Rev    : 1.0 - initial release
// ============================================================================
module pam_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int TW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_x,
  input  logic [8*NREQ-1:0] req_y,
  input  logic              approx_en,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_z,
  output logic [TW-1:0]     resp_tag,
  output logic              resp_approx,
  input  logic              cnt_clr,
  output logic [15:0]       op_cnt
);

  localparam int                 c_SUM_W   = TW + 1;
  localparam logic [c_SUM_W-1:0] c_NREQ    = c_SUM_W'(NREQ);
  localparam logic [TW-1:0]      c_PTR_RST = TW'(NREQ - 1);
  localparam logic [15:0]        c_CNT_MAX = 16'hFFFF;

  // Exact product, or the l=2 approximation: truncated x[7:2] partial
  // products plus the two compensation terms built from x[1:0].
  function automatic logic [15:0] f_mul(input logic [7:0] x,
                                        input logic [7:0] y,
                                        input logic       approx);
    logic [15:0] w_hi;
    logic [15:0] w_c1;
    logic [15:0] w_c2;
    w_hi = ({10'd0, x[7:2]} * {8'd0, y}) << 2;
    w_c1 = {8'd0, (x[0] & y[5]) | (x[1] & y[5]), 7'd0} +
           {7'd0, x[1] & y[7], 8'd0};
    w_c2 = {8'd0, (x[0] & y[7]) | (x[1] & y[6]), 7'd0};
    if (approx) f_mul = w_hi + w_c1 + w_c2;
    else        f_mul = {8'd0, x} * {8'd0, y};
  endfunction

  logic [TW-1:0]      r_ptr;
  logic               r_valid_a;
  logic [TW-1:0]      r_tag_a;
  logic [7:0]         r_x_a;
  logic [7:0]         r_y_a;
  logic               r_approx_a;
  logic               r_valid_b;
  logic [TW-1:0]      r_tag_b;
  logic [15:0]        r_z_b;
  logic               r_approx_b;
  logic [15:0]        r_op_cnt;

  logic               w_adv_a;
  logic               w_adv_b;
  logic [2*NREQ-1:0]  w_req_dbl;
  logic [c_SUM_W-1:0] w_shift;
  logic [NREQ-1:0]    w_req_rot;
  logic               w_any;
  logic [c_SUM_W-1:0] w_off;
  logic [c_SUM_W-1:0] w_sum;
  logic [TW-1:0]      w_win;
  logic               w_accept;
  logic [7:0]         w_sel_x;
  logic [7:0]         w_sel_y;
  logic [15:0]        w_z_a;
  logic               w_fire;

  assign w_adv_b = !r_valid_b || resp_ready;
  assign w_adv_a = !r_valid_a || w_adv_b;

  // Rotate the request vector so bit 0 is the requester right after r_ptr.
  assign w_req_dbl = {req_valid, req_valid};
  assign w_shift   = {1'b0, r_ptr} + c_SUM_W'(1);
  assign w_req_rot = NREQ'(w_req_dbl >> w_shift);

  always_comb begin
    w_any = 1'b0;
    w_off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_req_rot[j]) begin
        w_any = 1'b1;
        w_off = c_SUM_W'(j);
      end
    end
  end

  assign w_sum    = {1'b0, r_ptr} + c_SUM_W'(1) + w_off;
  assign w_win    = TW'((w_sum >= c_NREQ) ? (w_sum - c_NREQ) : w_sum);
  assign w_accept = w_any && w_adv_a;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_win] = 1'b1;
  end

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == TW'(i)) begin
        w_sel_x = req_x[8*i +: 8];
        w_sel_y = req_y[8*i +: 8];
      end
    end
  end

  // Stage A: captured operands; ptr only moves on an actual accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_a  <= 1'b0;
      r_tag_a    <= '0;
      r_x_a      <= '0;
      r_y_a      <= '0;
      r_approx_a <= 1'b0;
      r_ptr      <= c_PTR_RST;
    end else if (w_adv_a) begin
      r_valid_a <= w_accept;
      if (w_accept) begin
        r_tag_a    <= w_win;
        r_x_a      <= w_sel_x;
        r_y_a      <= w_sel_y;
        r_approx_a <= approx_en;
        r_ptr      <= w_win;
      end
    end
  end

  assign w_z_a = f_mul(r_x_a, r_y_a, r_approx_a);

  // Stage B: registered product, drives the response port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_b  <= 1'b0;
      r_tag_b    <= '0;
      r_z_b      <= '0;
      r_approx_b <= 1'b0;
    end else if (w_adv_b) begin
      r_valid_b <= r_valid_a;
      if (r_valid_a) begin
        r_tag_b    <= r_tag_a;
        r_z_b      <= w_z_a;
        r_approx_b <= r_approx_a;
      end
    end
  end

  assign w_fire = r_valid_b && resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_cnt <= '0;
    end else if (cnt_clr) begin
      r_op_cnt <= '0;
    end else if (w_fire && (r_op_cnt != c_CNT_MAX)) begin
      r_op_cnt <= r_op_cnt + 16'd1;
    end
  end

  assign resp_valid  = r_valid_b;
  assign resp_z      = r_z_b;
  assign resp_tag    = r_tag_b;
  assign resp_approx = r_approx_b;
  assign op_cnt      = r_op_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pam_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_pam_mul_arbiter
// Scoreboard bench: directed + random requests against a behavioural model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pam_mul_arbiter;

  localparam int NREQ = 4;
  localparam int TW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_x;
  logic [8*NREQ-1:0] req_y;
  logic              approx_en;
  logic              resp_valid;
  logic              resp_ready;
  logic [15:0]       resp_z;
  logic [TW-1:0]     resp_tag;
  logic              resp_approx;
  logic              cnt_clr;
  logic [15:0]       op_cnt;

  pam_mul_arbiter #(.NREQ(NREQ), .TW(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .approx_en  (approx_en),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_z     (resp_z),
    .resp_tag   (resp_tag),
    .resp_approx(resp_approx),
    .cnt_clr    (cnt_clr),
    .op_cnt     (op_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [15:0]   z;
    logic          ap;
    int            acc_cyc;
  } exp_t;

  exp_t            sb[$];
  int              grants[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  int              cyc     = 0;
  int              n_resp  = 0;
  int              n_acc   = 0;
  int              m_ptr   = NREQ - 1;
  int              m_cnt   = 0;
  logic [NREQ-1:0] acc_vec = '0;

  int              mon_w;
  logic [NREQ-1:0] mon_rdy;
  bit              mon_ev;
  bit              mon_fire;
  exp_t            mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Product defined straight from the arithmetic rules, bit by bit.
  function automatic int ref_mul(input int x, input int y, input bit ap);
    int xb0, xb1, y5, y6, y7;
    if (!ap) return x * y;
    xb0 = x % 2;        xb1 = (x / 2) % 2;
    y5  = (y / 32) % 2; y6  = (y / 64) % 2; y7 = (y / 128) % 2;
    return 4 * (y * (x / 4))
         + (((xb0 | xb1) & y5) * 128) + ((xb1 & y7) * 256)
         + (((xb0 & y7) | (xb1 & y6)) * 128);
  endfunction

  function automatic int ref_winner(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: queue depth is the number of accepted-but-undelivered requests.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_ptr   = NREQ - 1;
      m_cnt   = 0;
      acc_vec = '0;
    end else begin
      chk("op_cnt", 32'(op_cnt), 32'(m_cnt));
      mon_ev = (sb.size() > 0) && (sb[0].acc_cyc != cyc);
      chk("resp_valid", 32'(resp_valid), 32'(mon_ev));
      if (resp_valid && sb.size() > 0) begin
        chk("resp_tag", 32'(resp_tag), 32'(sb[0].tag));
        chk("resp_z", 32'(resp_z), 32'(sb[0].z));
        chk("resp_approx", 32'(resp_approx), 32'(sb[0].ap));
      end
      mon_w   = ref_winner(m_ptr, req_valid);
      mon_rdy = '0;
      if (mon_w >= 0 && (sb.size() < 2 || resp_ready)) mon_rdy[mon_w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(mon_rdy));
      if (resp_valid && resp_ready) n_resp++;
      mon_fire = mon_ev && resp_ready;
      if (mon_fire) void'(sb.pop_front());
      if (cnt_clr) m_cnt = 0;
      else if (mon_fire && m_cnt < 65535) m_cnt++;
      acc_vec = req_ready & req_valid;
      if ((mon_rdy & req_valid) != '0) begin
        mon_e.tag     = TW'(mon_w);
        mon_e.z       = 16'(ref_mul(int'(req_x[8*mon_w +: 8]), int'(req_y[8*mon_w +: 8]), approx_en));
        mon_e.ap      = approx_en;
        mon_e.acc_cyc = cyc + 1;
        sb.push_back(mon_e);
        m_ptr = mon_w;
      end
    end
  end

  task automatic new_req(input int i);
    logic [7:0] x;
    logic [7:0] y;
    x = 8'($urandom);
    y = 8'($urandom);
    if ($urandom_range(0, 7) == 0) x = 8'hFF;
    if ($urandom_range(0, 7) == 0) y = 8'hFF;
    req_x[8*i +: 8] = x;
    req_y[8*i +: 8] = y;
    req_valid[i]    = 1'b1;
  endtask

  // One clock: retire requests the DUT accepted, optionally refill/randomise.
  task automatic tick(input int fill, input bit rnd);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_vec[i]) begin
        req_valid[i] = 1'b0;
        n_acc++;
        grants.push_back(i);
      end
      if (rst_n && !req_valid[i] && $urandom_range(1, 100) <= fill) new_req(i);
    end
    if (rnd) begin
      approx_en  = 1'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      cnt_clr    = ($urandom_range(0, 49) == 0);
    end
  endtask

  task automatic issue(input int i, input logic [7:0] x, input logic [7:0] y, input logic ap);
    req_x[8*i +: 8] = x;
    req_y[8*i +: 8] = y;
    approx_en       = ap;
    req_valid[i]    = 1'b1;
    for (int t = 0; t < 20 && req_valid[i]; t++) tick(0, 1'b0);
    chk("issue_accept", 32'(req_valid[i]), 32'd0);
    req_valid[i] = 1'b0;
  endtask

  int n0;
  int r0;

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_x      = '0;
    req_y      = '0;
    approx_en  = 1'b0;
    resp_ready = 1'b1;
    cnt_clr    = 1'b0;
    repeat (3) tick(0, 1'b0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_z", 32'(resp_z), 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    chk("rst_resp_approx", 32'(resp_approx), 32'd0);
    chk("rst_op_cnt", 32'(op_cnt), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick(0, 1'b0);

    issue(0, 8'd255, 8'd255, 1'b0);
    repeat (3) tick(0, 1'b0);
    chk("single_op_cnt", 32'(op_cnt), 32'd1);

    issue(0, 8'd255, 8'd255, 1'b1);
    issue(1, 8'd3, 8'd255, 1'b1);
    issue(2, 8'd3, 8'hA0, 1'b1);
    issue(3, 8'd4, 8'd10, 1'b1);
    repeat (3) tick(0, 1'b0);

    // Fairness: every requester valid on every cycle.
    grants.delete();
    approx_en = 1'b0;
    for (int i = 0; i < NREQ; i++) new_req(i);
    repeat (16) tick(100, 1'b0);
    chk("rr_count", 32'(grants.size()), 32'd16);
    for (int k = 0; k < 16 && k < grants.size(); k++)
      chk("rr_order", 32'(grants[k]), 32'(k % NREQ));

    // Backpressure: only two requests can be buffered.
    repeat (8) tick(0, 1'b0);
    resp_ready = 1'b0;
    n0 = n_acc;
    r0 = n_resp;
    for (int i = 0; i < NREQ; i++) new_req(i);
    repeat (6) tick(0, 1'b0);
    chk("bp_accepts", 32'(n_acc - n0), 32'd2);
    resp_ready = 1'b1;
    repeat (10) tick(0, 1'b0);
    chk("bp_drain_accepts", 32'(n_acc - n0), 32'd4);
    chk("bp_drain_resps", 32'(n_resp - r0), 32'd4);

    // Async reset with both stages occupied.
    resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) new_req(i);
    repeat (4) tick(0, 1'b0);
    chk("pre_rst_valid", 32'(resp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(resp_valid), 32'd0);
    chk("rst_async_cnt", 32'(op_cnt), 32'd0);
    req_valid = '0;
    repeat (2) tick(0, 1'b0);
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    grants.delete();
    for (int i = 0; i < NREQ; i++) new_req(i);
    tick(0, 1'b0);
    chk("post_rst_grant", (grants.size() > 0) ? 32'(grants[0]) : 32'hFFFF_FFFF, 32'd0);
    repeat (8) tick(0, 1'b0);

    repeat (400) tick(60, 1'b1);
    resp_ready = 1'b1;
    cnt_clr    = 1'b0;
    repeat (10) tick(0, 1'b0);

    // Saturating counter, then clear colliding with a handshake.
    cnt_clr = 1'b1;
    tick(0, 1'b0);
    cnt_clr = 1'b0;
    chk("cnt_clr_idle", 32'(op_cnt), 32'd0);
    repeat (65545) tick(100, 1'b0);
    chk("cnt_saturated", 32'(op_cnt), 32'hFFFF);
    repeat (4) tick(100, 1'b0);
    chk("cnt_hold", 32'(op_cnt), 32'hFFFF);
    cnt_clr = 1'b1;
    tick(100, 1'b0);
    cnt_clr = 1'b0;
    chk("cnt_clr_fire", 32'(op_cnt), 32'd0);
    tick(100, 1'b0);

    req_valid = '0;
    repeat (6) tick(0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pam_mul_arbiter.md
# pam_mul_arbiter

Round-robin arbiter and two-stage pipeline that shares one 8x8 unsigned multiplier core among NREQ requesters. Each accepted request is computed exactly or with the l=2 approximate product, selected per request. The result returns tagged with the requester index. The block sits between operand producers and the shared multiplier datapath, and counts completed operations for error and energy characterisation runs.

## Interface
- NREQ, 4: number of requesters (2..8); TW = clog2(NREQ) tag width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_x  in  8*NREQ  operand x, requester i in bits [8i+7:8i]
- req_y  in  8*NREQ  operand y, same packing
- approx_en  in  1  sampled with each accepted request: 1 = approximate, 0 = exact
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accept
- resp_z  out  16  product
- resp_tag  out  TW  index of originating requester
- resp_approx  out  1  approx_en captured with this request
- cnt_clr  in  1  synchronous clear of op counter
- op_cnt  out  16  completed responses, saturating

## Operation
- Stage A register: valid_a, tag, x, y, approx. Stage B register: valid_b, tag, z, approx. Stage B drives the resp_* outputs.
- advance_b = !valid_b | resp_ready.
- advance_a = !valid_a | advance_b.
- Arbitration, combinational: priority order starts at (ptr+1) mod NREQ and wraps. The first requester with req_valid set wins.
- req_ready[win] = advance_a. All other req_ready bits are 0. All bits are 0 when no req_valid is set.
- Handshake: accept when req_valid[i] & req_ready[i]. On accept, stage A loads the operands, tag=i, and approx_en; ptr<=i.
- ptr changes only on accept. No grant is issued without a request.
- Stage A→B on advance_b & valid_a. If advance_a is true and nothing is accepted, valid_a clears.
- Multiplier function (computed from stage A, registered into B):
  - exact: z = x*y.
  - approximate: z = 4*(y*x[7:2]) + C1 + C2, where
    - C1 = ((x0&y5)|(x1&y5))·2^7 + (x1&y7)·2^8
    - C2 = ((x0&y7)|(x1&y6))·2^7
  - All terms are unsigned and summed to 16 bits with no overflow. The maximum is 64772.
- op_cnt increments on resp_valid & resp_ready and saturates at 0xFFFF.
- cnt_clr forces op_cnt to 0 and has priority over a same-cycle increment.
- Requesters must hold req_x, req_y and req_valid stable until accepted. The block never drops or duplicates an accepted request.

## Timing
- Reset (async assert, sync release): valid_a=valid_b=0, resp_valid=0, resp_z=0, resp_tag=0, resp_approx=0, op_cnt=0, ptr=NREQ-1 (requester 0 has first priority). req_ready follows the combinational rules (all 0 with no requests).
- Reset mid-operation discards all in-flight requests with no response.
- Latency: a request accepted at edge k presents resp_valid at edge k+1, i.e. one cycle after acceptance.
- Throughput: one accept per cycle while resp_ready=1.
- Backpressure: with resp_ready=0 and both stages full, all req_ready bits are 0 and resp_* hold stable.
- When resp_ready deasserts, at most two accepted requests are buffered.
- A simultaneous resp_ready and new accept with both stages full moves B out, A→B, and the new request into A in the same edge.

## Test plan
- Single request, exact: req 0, x=255, y=255, approx_en=0 → one cycle later resp_z=65025, resp_tag=0, resp_approx=0; op_cnt=1 after the handshake.
- Approximate arithmetic: x=255, y=255 → 64772. x=3, y=255 → 512. x=3, y=0xA0 → 512 (exact 480). x=4, y=10 → 40.
- Round-robin fairness: all 4 requesters valid continuously, resp_ready=1 → grant order 0,1,2,3,0,…; resp_tag follows the same sequence with back-to-back resp_valid.
- Backpressure: resp_ready=0 with requests pending → exactly 2 accepts, then req_ready=0 and resp_z frozen. Release resp_ready → responses drain in order with no loss.
- Async reset mid-stream: assert rst_n=0 while both stages are valid → resp_valid drops immediately. After release, the next grant goes to requester 0 and op_cnt=0.
- Counter: preload near 0xFFFF through repeated handshakes → holds at 0xFFFF. cnt_clr together with a handshake → op_cnt=0.
